// File: rtl/chess_clock_timer.sv
// Two-player chess clock: per-player BCD countdown with Fischer increment,
// pause, expiry flags and an internal 1 Hz prescaler.

module chess_clock_lane #(
  parameter int INCREMENT = 0
) (
  input  logic [15:0] t_i,
  output logic [15:0] dec_o,
  output logic [15:0] inc_o
);
  logic [7:0] sec_sum, sec_n, min_sum;
  logic       carry;

  // One-second BCD decrement; callers never decrement 00:00.
  always_comb begin
    dec_o = t_i;
    if (t_i[3:0] != 4'd0) begin
      dec_o[3:0] = t_i[3:0] - 4'd1;
    end else begin
      dec_o[3:0] = 4'd9;
      if (t_i[7:4] != 4'd0) begin
        dec_o[7:4] = t_i[7:4] - 4'd1;
      end else begin
        dec_o[7:4] = 4'd5;
        if (t_i[11:8] != 4'd0) begin
          dec_o[11:8] = t_i[11:8] - 4'd1;
        end else begin
          dec_o[11:8]  = 4'd9;
          dec_o[15:12] = t_i[15:12] - 4'd1;
        end
      end
    end
  end

  // Increment via small binary sums, saturating at 99:59.
  always_comb begin
    sec_sum = 8'(t_i[7:4]) * 8'd10 + 8'(t_i[3:0]) + 8'(INCREMENT);
    carry   = (sec_sum >= 8'd60);
    sec_n   = carry ? sec_sum - 8'd60 : sec_sum;
    min_sum = 8'(t_i[15:12]) * 8'd10 + 8'(t_i[11:8]) + {7'd0, carry};
    if (min_sum > 8'd99)
      inc_o = 16'h9959;
    else
      inc_o = {4'(min_sum / 8'd10), 4'(min_sum % 8'd10),
               4'(sec_n / 8'd10), 4'(sec_n % 8'd10)};
  end
endmodule

module chess_clock_timer #(
  parameter int CLOCK_FREQUENCY = 50_000_000,
  parameter int MINUTES         = 5,
  parameter int SECONDS         = 0,
  parameter int INCREMENT       = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        new_game,
  input  logic        start,
  input  logic        turn_end,
  input  logic        pause,
  output logic [15:0] a_time,
  output logic [15:0] b_time,
  output logic        active,
  output logic        running,
  output logic        a_flag,
  output logic        b_flag
);
  localparam int PW = $clog2(CLOCK_FREQUENCY);
  localparam logic [PW-1:0] PTOP = PW'(CLOCK_FREQUENCY - 1);
  localparam logic [15:0] INIT = {4'(MINUTES / 10), 4'(MINUTES % 10),
                                  4'(SECONDS / 10), 4'(SECONDS % 10)};

  typedef enum logic [2:0] {S_IDLE, S_RUN_A, S_RUN_B, S_PAUSED, S_EXPIRED} state_e;

  state_e            state_q, state_d;
  logic [1:0][15:0]  time_q, time_d, dec, inc;
  logic [1:0]        flag_q, flag_d;
  logic              active_q, active_d, running_q, running_d;
  logic [PW-1:0]     presc_q, presc_d;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    chess_clock_lane #(.INCREMENT(INCREMENT)) u_lane (
      .t_i  (time_q[g]),
      .dec_o(dec[g]),
      .inc_o(inc[g])
    );
  end

  always_comb begin
    state_d  = state_q;
    time_d   = time_q;
    flag_d   = flag_q;
    active_d = active_q;
    presc_d  = presc_q;
    if (new_game) begin
      state_d  = S_IDLE;
      time_d   = {INIT, INIT};
      flag_d   = 2'b00;
      active_d = 1'b0;
      presc_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (start) state_d = S_RUN_A;
        S_RUN_A, S_RUN_B: begin
          if (pause) begin
            state_d = S_PAUSED;
          end else if (turn_end) begin
            // A tick landing on the same edge is dropped.
            time_d[active_q] = inc[active_q];
            active_d         = ~active_q;
            state_d          = active_q ? S_RUN_A : S_RUN_B;
            presc_d          = '0;
          end else if (presc_q == PTOP) begin
            presc_d          = '0;
            time_d[active_q] = dec[active_q];
            if (dec[active_q] == 16'h0000) begin
              flag_d[active_q] = 1'b1;
              state_d          = S_EXPIRED;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        S_PAUSED: if (!pause) state_d = active_q ? S_RUN_B : S_RUN_A;
        S_EXPIRED: ;
        default: state_d = S_IDLE;
      endcase
    end
    running_d = (state_d == S_RUN_A) || (state_d == S_RUN_B);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      time_q    <= {INIT, INIT};
      flag_q    <= 2'b00;
      active_q  <= 1'b0;
      running_q <= 1'b0;
      presc_q   <= '0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      flag_q    <= flag_d;
      active_q  <= active_d;
      running_q <= running_d;
      presc_q   <= presc_d;
    end
  end

  assign a_time  = time_q[0];
  assign b_time  = time_q[1];
  assign a_flag  = flag_q[0];
  assign b_flag  = flag_q[1];
  assign active  = active_q;
  assign running = running_q;
endmodule

// File: tb/tb_chess_clock_timer.sv
// Scoreboard bench: three clock configurations share one stimulus stream and are
// checked every cycle against a seconds-based reference model.

module tb_chess_clock_timer;
  localparam int CF = 4, INC = 3, N = 3, MAXS = 5999;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        act;
    logic        run;
    logic        af;
    logic        bf;
  } obs_t;

  logic clock = 1'b0;
  logic reset, new_game, start, turn_end, pause;
  logic [15:0] a_t [N];
  logic [15:0] b_t [N];
  logic act [N], run [N], af [N], bf [N];

  always #5 clock = ~clock;

  chess_clock_timer #(.CLOCK_FREQUENCY(CF), .MINUTES(0), .SECONDS(12), .INCREMENT(INC)) u0 (
    .clock(clock), .reset(reset), .new_game(new_game), .start(start), .turn_end(turn_end),
    .pause(pause), .a_time(a_t[0]), .b_time(b_t[0]), .active(act[0]), .running(run[0]),
    .a_flag(af[0]), .b_flag(bf[0]));
  chess_clock_timer #(.CLOCK_FREQUENCY(CF), .MINUTES(1), .SECONDS(0), .INCREMENT(INC)) u1 (
    .clock(clock), .reset(reset), .new_game(new_game), .start(start), .turn_end(turn_end),
    .pause(pause), .a_time(a_t[1]), .b_time(b_t[1]), .active(act[1]), .running(run[1]),
    .a_flag(af[1]), .b_flag(bf[1]));
  chess_clock_timer #(.CLOCK_FREQUENCY(CF), .MINUTES(99), .SECONDS(58), .INCREMENT(INC)) u2 (
    .clock(clock), .reset(reset), .new_game(new_game), .start(start), .turn_end(turn_end),
    .pause(pause), .a_time(a_t[2]), .b_time(b_t[2]), .active(act[2]), .running(run[2]),
    .a_flag(af[2]), .b_flag(bf[2]));

  int base [N] = '{12, 60, 5998};
  int m_t [N][2];
  int m_mode [N], m_act [N], m_sub [N];
  bit m_flag [N][2];
  obs_t exp_q [N][$];
  int checks = 0, passes = 0, printed = 0;

  function automatic logic [15:0] bcd(int s);
    int m = s / 60, ss = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic void model_reset(int k);
    m_t[k][0] = base[k]; m_t[k][1] = base[k];
    m_mode[k] = M_IDLE; m_act[k] = 0; m_sub[k] = 0;
    m_flag[k][0] = 0; m_flag[k][1] = 0;
  endfunction

  function automatic void model_step(int k, bit ng, bit st, bit te, bit pa);
    int p = m_act[k];
    if (ng) begin model_reset(k); return; end
    case (m_mode[k])
      M_IDLE: if (st) m_mode[k] = M_RUN;
      M_RUN: begin
        if (pa) m_mode[k] = M_PAUSE;
        else if (te) begin
          m_t[k][p] = (m_t[k][p] + INC > MAXS) ? MAXS : m_t[k][p] + INC;
          m_act[k] = 1 - p;
          m_sub[k] = 0;
        end else if (m_sub[k] == CF - 1) begin
          m_sub[k] = 0;
          m_t[k][p] = m_t[k][p] - 1;
          if (m_t[k][p] == 0) begin m_flag[k][p] = 1; m_mode[k] = M_DONE; end
        end else m_sub[k] = m_sub[k] + 1;
      end
      M_PAUSE: if (!pa) m_mode[k] = M_RUN;
      default: ;
    endcase
  endfunction

  function automatic obs_t model_obs(int k);
    obs_t o;
    o.a = bcd(m_t[k][0]); o.b = bcd(m_t[k][1]);
    o.act = 1'(m_act[k]); o.run = (m_mode[k] == M_RUN);
    o.af = m_flag[k][0]; o.bf = m_flag[k][1];
    return o;
  endfunction

  function automatic obs_t dut_obs(int k);
    obs_t o;
    o.a = a_t[k]; o.b = b_t[k]; o.act = act[k]; o.run = run[k]; o.af = af[k]; o.bf = bf[k];
    return o;
  endfunction

  task automatic chk(input string name, input logic [35:0] got, input logic [35:0] want);
    checks++;
    if (got === want) passes++;
    else if (printed++ < 40) $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  // Drive one cycle at a negedge, predict, then wait for the next negedge.
  task automatic step(input bit ng, input bit st, input bit te, input bit pa);
    new_game = ng; start = st; turn_end = te; pause = pa;
    for (int k = 0; k < N; k++) begin
      model_step(k, ng, st, te, pa);
      exp_q[k].push_back(model_obs(k));
    end
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      model_reset(k);
      chk($sformatf("reset_u%0d", k), 36'(dut_obs(k)), 36'({bcd(base[k]), bcd(base[k]), 4'b0}));
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Monitor: every cycle the DUT presents registered outputs; compare against the queue.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      for (int k = 0; k < N; k++) begin
        if (exp_q[k].size() > 0) begin
          obs_t e, o;
          e = exp_q[k].pop_front();
          o = dut_obs(k);
          checks++;
          if (o === e) passes++;
          else if (printed++ < 40)
            $display("FAIL sb_u%0d: got %h want %h", k, o, e);
        end
      end
    end
  end

  initial begin
    bit pa_lvl;
    int te_div;
    reset = 1'b0; new_game = 0; start = 0; turn_end = 0; pause = 0;
    @(negedge clock);
    @(negedge clock);
    do_reset();

    step(0, 1, 0, 0);
    idle(4);
    chk("first_tick_a", 36'(a_t[0]), 36'h0011);
    chk("first_tick_b", 36'(b_t[0]), 36'h0012);
    chk("minute_borrow", 36'(a_t[1]), 36'h0059);
    idle(12);
    chk("a_at_8", 36'(a_t[0]), 36'h0008);
    step(0, 0, 1, 0);
    chk("turn_inc", 36'({a_t[0], 3'b0, act[0]}), 36'({16'h0011, 4'h1}));
    idle(8);
    chk("b_runs_a_frozen", 36'({a_t[0], b_t[0]}), 36'({16'h0011, 16'h0010}));

    idle(2);
    repeat (20) step(0, 0, 0, 1);
    chk("paused_hold", 36'({b_t[0], 3'b0, run[0]}), 36'({16'h0010, 4'h0}));
    idle(2);
    chk("resume_partial", 36'(b_t[0]), 36'h0010);
    idle(1);
    chk("resume_tick", 36'(b_t[0]), 36'h0009);

    step(1, 0, 0, 0);
    chk("ng_reload", 36'({a_t[0], b_t[0]}), 36'({16'h0012, 16'h0012}));
    step(0, 1, 0, 0);
    idle(47);
    chk("at_0001", 36'(a_t[0]), 36'h0001);
    step(0, 0, 1, 0);
    chk("tick_vs_turn", 36'({a_t[0], 3'b0, af[0]}), 36'({16'h0004, 4'h0}));

    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    chk("saturate", 36'(a_t[2]), 36'h9959);

    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    idle(48);
    chk("expire", 36'({a_t[0], 2'b0, af[0], run[0]}), 36'({16'h0000, 4'h2}));
    step(0, 0, 1, 0);
    step(0, 1, 0, 1);
    chk("expired_frozen", 36'({a_t[0], b_t[0], af[0], bf[0]}), 36'({16'h0000, 16'h0012, 2'b10}));
    step(1, 0, 0, 0);
    chk("ng_clear", 36'({a_t[0], b_t[0], af[0], bf[0]}), 36'({16'h0012, 16'h0012, 2'b00}));

    step(0, 1, 0, 0);
    idle(5);
    do_reset();

    pa_lvl = 0;
    te_div = 10;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) te_div = ($urandom_range(0, 1) == 0) ? 5 : 80;
      if ($urandom_range(0, 39) == 0) pa_lvl = ~pa_lvl;
      if ($urandom_range(0, 1499) == 0) do_reset();
      else step($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, te_div - 1) == 0, pa_lvl);
    end

    idle(1);
    @(negedge clock);
    checks++;
    if (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() == 0) passes++;
    else $display("FAIL drain: got %0d pending want 0",
                  exp_q[0].size() + exp_q[1].size() + exp_q[2].size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
